// File: rtl/rf_multiport_if.sv
// Bus bundle for rf_multiport: two write ports, NRD packed read ports,
// scrub control and status.
interface rf_multiport_if #(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 8,
    parameter int NRD    = 2
);
    localparam int AWIDTH = $clog2(DEPTH);

    logic                    wena0;
    logic [AWIDTH-1:0]       waddr0;
    logic [DWIDTH-1:0]       wdata0;
    logic                    wena1;
    logic [AWIDTH-1:0]       waddr1;
    logic [DWIDTH-1:0]       wdata1;
    logic [NRD*AWIDTH-1:0]   raddr;
    logic [NRD*DWIDTH-1:0]   rdata;
    logic [NRD-1:0]          rvalid;
    logic                    clr;
    logic                    busy;
    logic                    wdrop;

    modport master (
        output wena0, waddr0, wdata0, wena1, waddr1, wdata1, raddr, clr,
        input  rdata, rvalid, busy, wdrop
    );

    modport slave (
        input  wena0, waddr0, wdata0, wena1, waddr1, wdata1, raddr, clr,
        output rdata, rvalid, busy, wdrop
    );
endinterface

// File: rtl/rf_multiport.sv
// Multiport register file: two write ports, NRD read ports, optional bypass,
// optional hardwired-zero entry 0, per-entry valid bits and a sequential scrub engine.
module rf_multiport #(
    parameter int DWIDTH   = 64,
    parameter int DEPTH    = 8,
    parameter int NRD      = 2,
    parameter int RD_REG   = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic          clk,
    input  logic          rst,
    rf_multiport_if.slave io_rf
);
    localparam int AWIDTH = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SCRUB = 1'b1
    } state_t;

    state_t             r_state;
    logic [AWIDTH-1:0]  r_ptr;
    logic               r_busy;
    logic               r_wdrop;
    logic [DWIDTH-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;

    logic w_scrub;
    logic w_zero0;
    logic w_zero1;
    logic w_conflict;
    logic w_we0;
    logic w_we1;
    logic w_wdrop_next;

    assign w_scrub = (r_state == S_SCRUB);
    assign w_zero0 = (ZERO_REG != 0) && (io_rf.waddr0 == '0);
    assign w_zero1 = (ZERO_REG != 0) && (io_rf.waddr1 == '0);

    // Writes to the hardwired-zero entry are silently ignored, so they never count as a conflict.
    assign w_conflict   = io_rf.wena0 && io_rf.wena1 && (io_rf.waddr0 == io_rf.waddr1) && !w_zero0;
    assign w_we1        = io_rf.wena1 && !w_scrub && !w_zero1;
    assign w_we0        = io_rf.wena0 && !w_scrub && !w_zero0 && !w_conflict;
    assign w_wdrop_next = (w_scrub && (io_rf.wena0 || io_rf.wena1)) || (!w_scrub && w_conflict);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_wdrop <= 1'b0;
        end else begin
            r_wdrop <= w_wdrop_next;
            case (r_state)
                S_IDLE: begin
                    if (io_rf.clr) begin
                        r_state <= S_SCRUB;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SCRUB: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == AWIDTH'(DEPTH - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scrub has priority over writes, but writes are already gated off while scrubbing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst) begin
                r_mem[i]   <= '0;
                r_valid[i] <= 1'b0;
            end else if (w_scrub && (r_ptr == AWIDTH'(i))) begin
                r_mem[i]   <= '0;
                r_valid[i] <= 1'b0;
            end else if (w_we1 && (io_rf.waddr1 == AWIDTH'(i))) begin
                r_mem[i]   <= io_rf.wdata1;
                r_valid[i] <= 1'b1;
            end else if (w_we0 && (io_rf.waddr0 == AWIDTH'(i))) begin
                r_mem[i]   <= io_rf.wdata0;
                r_valid[i] <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AWIDTH-1:0] w_ra;
            logic [DWIDTH-1:0] w_rd;
            logic              w_rv;

            assign w_ra = io_rf.raddr[gi*AWIDTH +: AWIDTH];

            always_comb begin
                w_rd = r_mem[w_ra];
                w_rv = r_valid[w_ra];
                if (BYPASS != 0) begin
                    if (w_we1 && (io_rf.waddr1 == w_ra)) begin
                        w_rd = io_rf.wdata1;
                        w_rv = 1'b1;
                    end else if (w_we0 && (io_rf.waddr0 == w_ra)) begin
                        w_rd = io_rf.wdata0;
                        w_rv = 1'b1;
                    end
                end
                if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    w_rd = '0;
                    w_rv = 1'b1;
                end
            end

            if (RD_REG != 0) begin : g_reg
                logic [DWIDTH-1:0] r_rd;
                logic              r_rv;

                always_ff @(posedge clk) begin
                    if (!rst) begin
                        r_rd <= '0;
                        r_rv <= 1'b0;
                    end else begin
                        r_rd <= w_rd;
                        r_rv <= w_rv;
                    end
                end

                assign io_rf.rdata[gi*DWIDTH +: DWIDTH] = r_rd;
                assign io_rf.rvalid[gi]                 = r_rv;
            end else begin : g_comb
                assign io_rf.rdata[gi*DWIDTH +: DWIDTH] = w_rd;
                assign io_rf.rvalid[gi]                 = w_rv;
            end
        end
    endgenerate

    assign io_rf.busy  = r_busy;
    assign io_rf.wdrop = r_wdrop;
endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: default instance (comb read, bypass) and an
// alternate instance (registered read, no bypass, hardwired zero).
module tb_rf_multiport;
    logic clk;
    logic rst;

    rf_multiport_if #(.DWIDTH(64), .DEPTH(8), .NRD(2)) bus_a ();
    rf_multiport_if #(.DWIDTH(64), .DEPTH(8), .NRD(2)) bus_b ();

    rf_multiport #(
        .DWIDTH(64), .DEPTH(8), .NRD(2), .RD_REG(0), .BYPASS(1), .ZERO_REG(0)
    ) dut_a (
        .clk   (clk),
        .rst   (rst),
        .io_rf (bus_a)
    );

    rf_multiport #(
        .DWIDTH(64), .DEPTH(8), .NRD(2), .RD_REG(1), .BYPASS(0), .ZERO_REG(1)
    ) dut_b (
        .clk   (clk),
        .rst   (rst),
        .io_rf (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    string       q_tag [$];
    logic [63:0] q_exp [$];

    task automatic expect_val(input string tag, input logic [63:0] exp);
        q_tag.push_back(tag);
        q_exp.push_back(exp);
    endtask

    task automatic check(input logic [63:0] obs);
        string       tag;
        logic [63:0] exp;
        n_cmp++;
        if (q_exp.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
        end else begin
            tag = q_tag.pop_front();
            exp = q_exp.pop_front();
            assert (obs === exp) else begin
                n_bad++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.wena0 = 1'b0;
        bus_a.wena1 = 1'b0;
        bus_a.clr   = 1'b0;
    endtask

    task automatic idle_b();
        bus_b.wena0 = 1'b0;
        bus_b.wena1 = 1'b0;
        bus_b.clr   = 1'b0;
    endtask

    initial begin
        int n_busy;
        rst = 1'b0;
        idle_a();
        idle_b();
        bus_a.waddr0 = '0; bus_a.wdata0 = '0; bus_a.waddr1 = '0; bus_a.wdata1 = '0;
        bus_b.waddr0 = '0; bus_b.wdata0 = '0; bus_b.waddr1 = '0; bus_b.wdata1 = '0;
        bus_a.raddr  = '0;
        bus_b.raddr  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        expect_val("rst_a_busy", 0);    check(64'(bus_a.busy));
        expect_val("rst_a_wdrop", 0);   check(64'(bus_a.wdrop));
        expect_val("rst_a_rvalid", 0);  check(64'(bus_a.rvalid));
        expect_val("rst_a_rdata0", 0);  check(bus_a.rdata[63:0]);
        expect_val("rst_b_rdata0", 0);  check(bus_b.rdata[63:0]);
        expect_val("rst_b_busy", 0);    check(64'(bus_b.busy));
        rst = 1'b1;

        // 1: write addr1=17, read it back next cycle; addr3 still unwritten
        step();
        bus_a.raddr  = {3'd3, 3'd1};
        bus_a.wena0  = 1'b1; bus_a.waddr0 = 3'd1; bus_a.wdata0 = 64'd17;
        expect_val("t1_rdata0", 17);
        expect_val("t1_rvalid0", 1);
        expect_val("t1_rdata1", 0);
        expect_val("t1_rvalid1", 0);
        step();
        idle_a();
        #1;
        check(bus_a.rdata[63:0]);
        check(64'(bus_a.rvalid[0]));
        check(bus_a.rdata[127:64]);
        check(64'(bus_a.rvalid[1]));

        // 2: dual write same address, port 1 wins, wdrop next cycle
        step();
        bus_a.raddr  = {3'd2, 3'd2};
        bus_a.wena0  = 1'b1; bus_a.waddr0 = 3'd2; bus_a.wdata0 = 64'd85;
        bus_a.wena1  = 1'b1; bus_a.waddr1 = 3'd2; bus_a.wdata1 = 64'd9;
        #1;
        expect_val("t2_bypass_p1_prio", 9); check(bus_a.rdata[63:0]);
        expect_val("t2_wdrop", 1);
        expect_val("t2_entry2", 9);
        step();
        idle_a();
        #1;
        check(64'(bus_a.wdrop));
        check(bus_a.rdata[63:0]);
        expect_val("t2_wdrop_clear", 0);
        step();
        check(64'(bus_a.wdrop));

        // 3: same-cycle write/read of addr4; bypass on A, old value on B
        bus_a.raddr = {3'd0, 3'd4};
        bus_a.wena0 = 1'b1; bus_a.waddr0 = 3'd4; bus_a.wdata0 = 64'd7;
        bus_b.raddr = {3'd0, 3'd4};
        bus_b.wena0 = 1'b1; bus_b.waddr0 = 3'd4; bus_b.wdata0 = 64'd7;
        #1;
        expect_val("t3_a_bypass", 7);        check(bus_a.rdata[63:0]);
        expect_val("t3_a_bypass_valid", 1);  check(64'(bus_a.rvalid[0]));
        expect_val("t3_b_no_bypass_old", 0);
        expect_val("t3_b_after_write", 7);
        step();
        idle_a();
        idle_b();
        check(bus_b.rdata[63:0]);
        step();
        check(bus_b.rdata[63:0]);

        // 5: hardwired zero entry on B, and registered-read lag
        bus_b.raddr = {3'd0, 3'd0};
        bus_b.wena0 = 1'b1; bus_b.waddr0 = 3'd0; bus_b.wdata0 = 64'd31;
        expect_val("t5_zero_wdrop", 0);
        expect_val("t5_zero_read", 0);
        expect_val("t5_zero_valid", 1);
        step();
        idle_b();
        check(64'(bus_b.wdrop));
        check(bus_b.rdata[63:0]);
        check(64'(bus_b.rvalid[0]));
        bus_b.raddr = {3'd0, 3'd4};
        #1;
        expect_val("t5_lag_old_addr", 0);  check(bus_b.rdata[63:0]);
        expect_val("t5_lag_new_addr", 7);
        step();
        check(bus_b.rdata[63:0]);

        // 4: fill 1..7, scrub for exactly DEPTH cycles, write and clr during scrub
        for (int i = 1; i < 8; i++) begin
            bus_a.wena0 = 1'b1; bus_a.waddr0 = 3'(i); bus_a.wdata0 = 64'(i * 16 + 3);
            step();
        end
        idle_a();
        bus_a.raddr = {3'd7, 3'd5};
        #1;
        expect_val("t4_fill_5", 83);   check(bus_a.rdata[63:0]);
        expect_val("t4_fill_7", 115);  check(bus_a.rdata[127:64]);
        step();
        bus_a.clr = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            idle_a();
            expect_val($sformatf("t4_busy_c%0d", c), 1);
            check(64'(bus_a.busy));
            if (c == 3) begin
                expect_val("t4_scrub_wdrop", 1);
                check(64'(bus_a.wdrop));
            end
            if (c == 2) begin
                bus_a.wena1 = 1'b1; bus_a.waddr1 = 3'd1; bus_a.wdata1 = 64'd99;
            end
            if (c == 4) bus_a.clr = 1'b1;
        end
        step();
        idle_a();
        expect_val("t4_busy_done", 0);
        check(64'(bus_a.busy));
        for (int a = 0; a < 8; a++) begin
            bus_a.raddr = {3'(7 - a), 3'(a)};
            #1;
            expect_val($sformatf("t4_clear_rdata_%0d", a), 0);
            check(bus_a.rdata[63:0]);
            expect_val($sformatf("t4_clear_rvalid_%0d", a), 0);
            check(64'(bus_a.rvalid[0]));
        end

        // 6: reset in scrub cycle 3, then a fresh full scrub
        step();
        bus_a.wena0 = 1'b1; bus_a.waddr0 = 3'd3; bus_a.wdata0 = 64'd55;
        step();
        idle_a();
        bus_a.clr = 1'b1;
        step();
        bus_a.clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        expect_val("t6_busy_after_rst", 0);   check(64'(bus_a.busy));
        expect_val("t6_wdrop_after_rst", 0);  check(64'(bus_a.wdrop));
        rst = 1'b1;
        bus_a.raddr = {3'd0, 3'd3};
        #1;
        expect_val("t6_entry3_reset", 0);     check(bus_a.rdata[63:0]);
        expect_val("t6_valid3_reset", 0);     check(64'(bus_a.rvalid[0]));
        step();
        bus_a.clr = 1'b1;
        step();
        bus_a.clr = 1'b0;
        n_busy = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus_a.busy !== 1'b1) break;
            n_busy++;
            step();
        end
        expect_val("t6_rescrub_len", 8);
        check(64'(n_busy));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
